// File: rtl/psk8_search_ctrl.sv
// psk8_search_ctrl: scans eight 8-PSK candidates through a shared multiplier, tracking best symbol and survivor mask
module psk8_search_ctrl #(
  parameter int WIDTH = 32,
  localparam int MW = 2*WIDTH+2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] R_real,
  input  logic signed [WIDTH-1:0] R_imag,
  input  logic signed [WIDTH-1:0] Y_real,
  input  logic signed [WIDTH-1:0] Y_imag,
  input  logic        [MW-1:0]    radius,
  output logic signed [WIDTH-1:0] mul_R_real,
  output logic signed [WIDTH-1:0] mul_R_imag,
  output logic        [2:0]       mul_S,
  input  logic signed [WIDTH-1:0] mul_out_real,
  input  logic signed [WIDTH-1:0] mul_out_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [2:0]       best_S,
  output logic        [MW-1:0]    best_metric,
  output logic        [7:0]       survivor_mask,
  output logic                    found
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t st;
  logic [2:0] k;
  logic signed [WIDTH-1:0] rr, ri, yr, yi;
  logic [MW-1:0] rad;
  logic [2:0] wb_s, nb_s;
  logic [MW-1:0] wb_m, nb_m, metric;
  logic [7:0] wmask, nmask;
  logic signed [WIDTH:0] dr, di;
  logic signed [MW-1:0] dre, die;
  logic hit, upd;
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign mul_R_real = rr;
  assign mul_R_imag = ri;
  assign mul_S = st == SCAN ? k : 3'd7;
  // score the current candidate and fold it into the running best and mask
  always_comb begin
    dr = $signed({yr[WIDTH-1], yr}) - $signed({mul_out_real[WIDTH-1], mul_out_real});
    di = $signed({yi[WIDTH-1], yi}) - $signed({mul_out_imag[WIDTH-1], mul_out_imag});
    dre = MW'(dr);
    die = MW'(di);
    metric = MW'(dre * dre) + MW'(die * die);
    hit = metric <= rad;
    upd = k == 3'd0 || metric < wb_m;
    nb_s = upd ? k : wb_s;
    nb_m = upd ? metric : wb_m;
    nmask = (k == 3'd0 ? 8'd0 : wmask) | (8'(hit) << k);
  end
  // control FSM; result outputs only change on the edge entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      k <= 3'd0;
      rr <= '0;
      ri <= '0;
      yr <= '0;
      yi <= '0;
      rad <= '0;
      wb_s <= 3'd0;
      wb_m <= '0;
      wmask <= 8'd0;
      best_S <= 3'd0;
      best_metric <= '0;
      survivor_mask <= 8'd0;
      found <= 1'b0;
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          rr <= R_real;
          ri <= R_imag;
          yr <= Y_real;
          yi <= Y_imag;
          rad <= radius;
          k <= 3'd0;
          st <= SCAN;
        end
        SCAN: begin
          k <= k + 3'd1;
          wb_s <= nb_s;
          wb_m <= nb_m;
          wmask <= nmask;
          if (k == 3'd7) begin
            st <= DONE;
            best_S <= nb_s;
            best_metric <= nb_m;
            survivor_mask <= nmask;
            found <= |nmask;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psk8_search_ctrl.sv
// tb_psk8_search_ctrl: randomized self-checking bench with a behavioural candidate-scoring model
module tb_psk8_search_ctrl;
  localparam int W = 16;
  localparam int MW = 2*W+2;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic signed [W-1:0] r_re = 0, r_im = 0, y_re = 0, y_im = 0;
  logic [MW-1:0] radius = 0;
  logic signed [W-1:0] mul_r_re, mul_r_im, mo_re, mo_im;
  logic [2:0] mul_s, best_s;
  logic [MW-1:0] best_m;
  logic [7:0] mask;
  logic in_ready, out_valid, found;
  int checks = 0, errors = 0;
  int cq [8] = '{-256, 181, 0, -181, -181, 181, 0, 256};
  int sq [8] = '{0, 181, 256, 181, -181, -181, -256, 0};

  psk8_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .R_real(r_re), .R_imag(r_im), .Y_real(y_re), .Y_imag(y_im), .radius(radius),
    .mul_R_real(mul_r_re), .mul_R_imag(mul_r_im), .mul_S(mul_s),
    .mul_out_real(mo_re), .mul_out_imag(mo_im),
    .out_valid(out_valid), .out_ready(out_ready), .best_S(best_s),
    .best_metric(best_m), .survivor_mask(mask), .found(found)
  );

  always #5 clk = ~clk;

  // multiplier stand-in: R times a Q8 unit symbol looked up by S
  always_comb begin
    mo_re = W'((int'(mul_r_re) * cq[mul_s] - int'(mul_r_im) * sq[mul_s]) >>> 8);
    mo_im = W'((int'(mul_r_re) * sq[mul_s] + int'(mul_r_im) * cq[mul_s]) >>> 8);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint metric_of(input int rr, ri, yr, yi, s);
    int pr, pi, dr, di;
    pr = (rr * cq[s] - ri * sq[s]) >>> 8;
    pi = (rr * sq[s] + ri * cq[s]) >>> 8;
    dr = yr - pr;
    di = yi - pi;
    return longint'(dr) * dr + longint'(di) * di;
  endfunction

  task automatic model(input int rr, ri, yr, yi, input longint rad,
                       output int bs, output longint bm, output logic [7:0] em);
    longint m;
    bs = 0;
    bm = -1;
    em = 0;
    for (int s = 0; s < 8; s++) begin
      m = metric_of(rr, ri, yr, yi, s);
      if (bm < 0 || m < bm) begin
        bm = m;
        bs = s;
      end
      em[s] = m <= rad;
    end
  endtask

  task automatic scramble();
    r_re = W'($urandom);
    r_im = W'($urandom);
    y_re = W'($urandom);
    y_im = W'($urandom);
    radius = MW'($urandom);
  endtask

  task automatic run_req(input int rr, ri, yr, yi, input longint rad, input int hold);
    int bs;
    longint bm;
    logic [7:0] em;
    model(rr, ri, yr, yi, rad, bs, bm, em);
    @(negedge clk);
    r_re = W'(rr);
    r_im = W'(ri);
    y_re = W'(yr);
    y_im = W'(yi);
    radius = MW'(rad);
    in_valid = 1;
    out_ready = 0;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1 scramble();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("scan_mul_s", mul_s, i);
      chk("scan_mul_r_re", mul_r_re, rr);
      chk("scan_mul_r_im", mul_r_im, ri);
      chk("scan_out_valid", out_valid, 0);
      chk("scan_in_ready", in_ready, 0);
      @(posedge clk);
      #1 scramble();
    end
    @(negedge clk);
    chk("done_out_valid", out_valid, 1);
    chk("best_s", best_s, bs);
    chk("best_metric", best_m, bm);
    chk("survivor_mask", mask, em);
    chk("found", found, |em);
    chk("done_mul_s", mul_s, 7);
    repeat (hold) begin
      @(posedge clk);
      #1 scramble();
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_best_s", best_s, bs);
      chk("hold_best_metric", best_m, bm);
      chk("hold_mask", mask, em);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
  endtask

  initial begin
    int rr, ri, yr, yi, n, nres, last_acc, cyc;
    longint rad;
    int qr[3], qi[3], qyr[3], qyi[3];
    longint qrad[3];
    int ebs;
    longint ebm;
    logic [7:0] eem;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_best_s", best_s, 0);
    chk("rst_best_metric", best_m, 0);
    chk("rst_mask", mask, 0);
    chk("rst_found", found, 0);
    chk("rst_mul_s", mul_s, 7);
    chk("rst_mul_r_re", mul_r_re, 0);
    run_req(256, 0, 0, 256, 0, 0);
    run_req(0, 0, 100, -50, 1000, 1);
    run_req(256, 0, 256, 0, 131072, 5);
    for (int t = 0; t < 8; t++) begin
      rr = int'($urandom_range(6000)) - 3000;
      ri = int'($urandom_range(6000)) - 3000;
      yr = int'($urandom_range(6000)) - 3000;
      yi = int'($urandom_range(6000)) - 3000;
      rad = metric_of(rr, ri, yr, yi, int'($urandom_range(7)));
      if (t % 3 == 1) rad = rad - 1;
      if (t % 3 == 2) rad = longint'($urandom);
      run_req(rr, ri, yr, yi, rad, int'($urandom_range(3)));
    end
    // reset in the middle of a scan
    @(negedge clk);
    r_re = 300;
    r_im = -20;
    y_re = 10;
    y_im = 40;
    radius = 5000;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_scan_k4", mul_s, 4);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_best_s", best_s, 0);
    chk("midrst_best_metric", best_m, 0);
    chk("midrst_mask", mask, 0);
    chk("midrst_found", found, 0);
    chk("midrst_mul_s", mul_s, 7);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
    end
    run_req(-1200, 700, 450, -900, 400000, 2);
    // back-to-back with both handshakes held high
    for (int j = 0; j < 3; j++) begin
      qr[j] = int'($urandom_range(6000)) - 3000;
      qi[j] = int'($urandom_range(6000)) - 3000;
      qyr[j] = int'($urandom_range(6000)) - 3000;
      qyi[j] = int'($urandom_range(6000)) - 3000;
      qrad[j] = metric_of(qr[j], qi[j], qyr[j], qyi[j], j * 3);
    end
    n = 0;
    nres = 0;
    last_acc = -1;
    cyc = 0;
    out_ready = 1;
    while (nres < 3 && cyc < 60) begin
      @(negedge clk);
      if (out_valid) begin
        model(qr[nres], qi[nres], qyr[nres], qyi[nres], qrad[nres], ebs, ebm, eem);
        chk("b2b_best_s", best_s, ebs);
        chk("b2b_best_metric", best_m, ebm);
        chk("b2b_mask", mask, eem);
        nres++;
      end
      if (in_ready) begin
        if (last_acc >= 0) chk("b2b_interval", cyc - last_acc, 10);
        last_acc = cyc;
        if (n < 3) begin
          r_re = W'(qr[n]);
          r_im = W'(qi[n]);
          y_re = W'(qyr[n]);
          y_im = W'(qyi[n]);
          radius = MW'(qrad[n]);
          in_valid = 1;
          n++;
        end else in_valid = 0;
      end
      cyc++;
    end
    chk("b2b_results", nres, 3);
    in_valid = 0;
    out_ready = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
